adder_arbiter: RTL and testbench
================================

# adder_arbiter

Round-robin scheduler that shares one 9-bit signed `adder` instance (add/subtract datapath, `sinal` selects the operation) among `N_REQ` requesters. Each requester raises `req` with its operands. The arbiter grants one requester, latches that requester's operands, and drives the shared adder. It then registers the result plus an overflow flag and pulses `done` to the owning requester. It sits between the requesting control blocks and the single adder, so no requester drives the adder directly.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `WIDTH`, 9, operand/result width, two's complement
- `clock`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `req`  in  N_REQ  per-requester request, level, held until `ack`
- `a_in`  in  N_REQ*WIDTH  operand a; requester i uses bits [i*WIDTH +: WIDTH]
- `b_in`  in  N_REQ*WIDTH  operand b, packed the same way
- `sinal_in`  in  N_REQ  0 = a+b, 1 = a−b
- `ack`  out  N_REQ  one-hot, one-cycle pulse; the granted requester's operands are latched
- `done`  out  N_REQ  one-hot, one-cycle pulse; `res`/`ovf` are valid for the owner
- `res`  out  WIDTH  registered signed result; held until the next capture
- `ovf`  out  1  registered signed overflow of the last operation
- `busy`  out  1  high whenever the FSM is not in IDLE

## Operation
- The FSM has three states:
  - IDLE: if any `req` bit is high, pick grant g by round-robin starting at `ptr`. Latch `a_in[g]`, `b_in[g]` and `sinal_in[g]` into operand registers, set `grant_q <= g`, and go to EXEC. Otherwise stay in IDLE.
  - EXEC: `ack[grant_q]` = 1. Capture `res <= soma` and compute `ovf`. Go to DONE.
  - DONE: `done[grant_q]` = 1. Set `ptr <= (grant_q + 1) mod N_REQ`. Go to IDLE.
- Round-robin search order is `ptr`, `ptr+1`, …, wrapping at N_REQ−1 back to 0. `ptr` resets to 0.
- `req` is sampled only in IDLE. A `req` that stays high after `ack` is treated as a new request at the next IDLE.
- `ack`, `done` and `busy` are decoded from the state and `grant_q` registers only (Moore outputs, glitch-free).
- Arithmetic: the `adder` receives the latched operands, and its `soma` is WIDTH bits, wrapping modulo 2^WIDTH.
- Overflow rules:
  - Add: `ovf` = (a[MSB] == b[MSB]) && (soma[MSB] != a[MSB]).
  - Subtract: `ovf` = (a[MSB] != b[MSB]) && (soma[MSB] != a[MSB]).
- Reset (asynchronous, any state) clears: state = IDLE, `ptr` = 0, `grant_q` = 0, operand registers = 0, `res` = 0, `ovf` = 0. As a result, `ack`, `done` and `busy` are all 0. An operation in flight is dropped and no `done` is issued.

## Timing
- If `req[i]` is high at rising edge T while IDLE, then `ack[i]` is high in cycle T..T+1 and `done[i]` is high in cycle T+1..T+2. `res` is valid from edge T+1 and stays stable through `done` and beyond.
- Back-to-back throughput is one operation per 3 cycles. IDLE lasts exactly one cycle when a request is pending.
- Simultaneous requests are served in round-robin order, one per 3-cycle slot.
- No requester waits more than N_REQ slots.
- Operand changes after `ack` have no effect on the current operation.
- Reset deassertion is synchronised externally. The first grant is possible at the first edge with `reset_n` high.

## Structure
- Shared package `adder_pkg` holds:
  - `WIDTH_DEFAULT = 9`
  - state typedef `arb_state_t` {IDLE, EXEC, DONE}
  - the overflow function `ovf_calc(a, b, s, sinal)`
- The existing `adder` is instantiated once, unmodified.
- One natural sub-module is `rr_pick`, which is combinational: given `req` and `ptr`, it returns one-hot `grant`, its index, and `any`.

## Test plan
- Single request: `req[0]` with a = −1, b = 4, `sinal` = 1. Expect `ack[0]` 1 cycle later, `done[0]` 2 cycles later, `res` = −5, `ovf` = 0.
- Add overflow: `req[1]` with a = 200, b = 100, `sinal` = 0. Expect `res` = −212, `ovf` = 1, `done[1]` only.
- Subtract overflow: `req[2]` with a = −256, b = 1, `sinal` = 1. Expect `res` = 255, `ovf` = 1.
- All four `req` held high from reset. Expect grants in order 0, 1, 2, 3, 0 at 3-cycle spacing, each `res` matching its own requester's operands.
- Fairness: `req[0]` and `req[2]` held high continuously. Expect grants to alternate 0, 2, 0, 2, with `req[1]` and `req[3]` never acked.
- Mid-operation reset: pull `reset_n` low during EXEC. Expect no `done`, `res` = 0, `ovf` = 0 and `busy` = 0 immediately. After release, with `req[3]` and `req[0]` both high, the first grant goes to 0.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and helpers for the adder arbiter: state encoding and the
// signed-overflow rule used when the shared adder result is captured.
package adder_pkg;

  localparam int WIDTH_DEFAULT = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  // Works on sign bits only, so it stays independent of the operand width.
  function automatic logic ovf_calc(input logic a, input logic b,
                                    input logic s, input logic sinal);
    if (sinal)
      return (a != b) && (s != a);
    else
      return (a == b) && (s != a);
  endfunction

endpackage

// File: rtl/adder.sv
// Shared two's complement add/subtract datapath; sinal = 1 selects a - b.
// The result wraps modulo 2^WIDTH.
module adder #(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sinal,
  output logic [WIDTH-1:0] soma
);

  assign soma = sinal ? (a - b) : (a + b);

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted req at or after ptr,
// wrapping at N_REQ-1 back to 0.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    idx,
  output logic             any_req
);

  logic [IW:0]   pos_w;
  logic [IW-1:0] pos;

  // Walk offsets from farthest to nearest so the one closest to ptr wins.
  always_comb begin
    idx   = '0;
    pos_w = '0;
    pos   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      pos_w = {1'b0, ptr} + (IW+1)'(k);
      if (pos_w >= (IW+1)'(N_REQ))
        pos_w = pos_w - (IW+1)'(N_REQ);
      pos = pos_w[IW-1:0];
      if (req[pos])
        idx = pos;
    end
  end

  always_comb begin
    any_req = |req;
    grant   = '0;
    if (any_req)
      grant[idx] = 1'b1;
  end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin scheduler sharing one adder among N_REQ requesters; ack, done
// and busy are Moore outputs decoded from state_q and grant_q.
//
//   state | meaning
//   IDLE  | sample req, latch winner's operands, record grant
//   EXEC  | ack owner, capture adder result and overflow
//   DONE  | done to owner, advance round-robin pointer past owner
module adder_arbiter
  import adder_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*WIDTH-1:0]  a_in,
  input  logic [N_REQ*WIDTH-1:0]  b_in,
  input  logic [N_REQ-1:0]        sinal_in,
  output logic [N_REQ-1:0]        ack,
  output logic [N_REQ-1:0]        done,
  output logic signed [WIDTH-1:0] res,
  output logic                    ovf,
  output logic                    busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t       state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    grant_q, grant_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             sinal_q, sinal_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             ovf_q, ovf_d;

  logic [N_REQ-1:0] pick_grant;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic [WIDTH-1:0] a_sel, b_sel, soma;
  logic             sinal_sel;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr_pick (
    .req     (req),
    .ptr     (ptr_q),
    .grant   (pick_grant),
    .idx     (pick_idx),
    .any_req (pick_any)
  );

  adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a     (a_q),
    .b     (b_q),
    .sinal (sinal_q),
    .soma  (soma)
  );

  // One-hot AND-OR operand mux driven by the picker's grant vector.
  always_comb begin
    a_sel     = '0;
    b_sel     = '0;
    sinal_sel = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_grant[i]) begin
        a_sel     = a_sel | a_in[i*WIDTH +: WIDTH];
        b_sel     = b_sel | b_in[i*WIDTH +: WIDTH];
        sinal_sel = sinal_sel | sinal_in[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    a_d     = a_q;
    b_d     = b_q;
    sinal_d = sinal_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          a_d     = a_sel;
          b_d     = b_sel;
          sinal_d = sinal_sel;
          grant_d = pick_idx;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d   = soma;
        ovf_d   = ovf_calc(a_q[WIDTH-1], b_q[WIDTH-1], soma[WIDTH-1], sinal_q);
        state_d = DONE;
      end
      DONE: begin
        ptr_d   = (grant_q == IW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sinal_q <= 1'b0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sinal_q <= sinal_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    ack  = '0;
    done = '0;
    if (state_q == EXEC)
      ack[grant_q] = 1'b1;
    if (state_q == DONE)
      done[grant_q] = 1'b1;
  end

  assign busy = (state_q != IDLE);
  assign res  = res_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: single ops, overflow corners, round-robin
// order, fairness and mid-operation reset.
module tb_adder_arbiter;

  localparam int N = 4;
  localparam int W = 9;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [N-1:0]      req = '0;
  logic [N*W-1:0]    a_in = '0;
  logic [N*W-1:0]    b_in = '0;
  logic [N-1:0]      sinal_in = '0;
  logic [N-1:0]      ack, done;
  logic signed [W-1:0] res;
  logic              ovf, busy;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  adder_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .req      (req),
    .a_in     (a_in),
    .b_in     (b_in),
    .sinal_in (sinal_in),
    .ack      (ack),
    .done     (done),
    .res      (res),
    .ovf      (ovf),
    .busy     (busy)
  );

  task automatic set_op(input int i, input int a, input int b, input logic s);
    a_in[i*W +: W] = W'(a);
    b_in[i*W +: W] = W'(b);
    sinal_in[i]    = s;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req = '0;
    repeat (3) @(negedge clock);
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack got %b want 0000", ack); end
    checks++; if (done !== 4'b0000) begin errors++; $display("FAIL reset_done got %b want 0000", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (res !== 9'd0) begin errors++; $display("FAIL reset_res got %0d want 0", res); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clock);
    set_op(0, -1, 4, 1'b1);
    req = 4'b0001;
    @(negedge clock);
    checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL single_ack got %b want 0001", ack); end
    checks++; if (done !== 4'b0000) begin errors++; $display("FAIL single_early_done got %b want 0000", done); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy); end
    req = 4'b0000;
    set_op(0, 100, 100, 1'b0);
    @(negedge clock);
    checks++; if (done !== 4'b0001) begin errors++; $display("FAIL single_done got %b want 0001", done); end
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL single_ack_clear got %b want 0000", ack); end
    checks++; if (res !== 9'(-5)) begin errors++; $display("FAIL single_res got %0d want -5", res); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL single_ovf got %b want 0", ovf); end
    @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy got %b want 0", busy); end
    checks++; if (done !== 4'b0000) begin errors++; $display("FAIL single_done_clear got %b want 0000", done); end
    checks++; if (res !== 9'(-5)) begin errors++; $display("FAIL single_res_hold got %0d want -5", res); end
  endtask

  task automatic test_add_ovf();
    set_op(1, 200, 100, 1'b0);
    req = 4'b0010;
    @(negedge clock);
    checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL addovf_ack got %b want 0010", ack); end
    req = 4'b0000;
    @(negedge clock);
    checks++; if (done !== 4'b0010) begin errors++; $display("FAIL addovf_done got %b want 0010", done); end
    checks++; if (res !== 9'(-212)) begin errors++; $display("FAIL addovf_res got %0d want -212", res); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL addovf_ovf got %b want 1", ovf); end
    @(negedge clock);
  endtask

  task automatic test_sub_ovf();
    set_op(2, -256, 1, 1'b1);
    req = 4'b0100;
    @(negedge clock);
    checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL subovf_ack got %b want 0100", ack); end
    req = 4'b0000;
    @(negedge clock);
    checks++; if (done !== 4'b0100) begin errors++; $display("FAIL subovf_done got %b want 0100", done); end
    checks++; if (res !== 9'd255) begin errors++; $display("FAIL subovf_res got %0d want 255", res); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL subovf_ovf got %b want 1", ovf); end
    @(negedge clock);
  endtask

  task automatic test_round_robin();
    int ea [4];
    int g;
    ea = '{30, -20, -200, 255};
    @(negedge clock);
    reset_n = 1'b0;
    set_op(0, 10, 20, 1'b0);
    set_op(1, 50, 70, 1'b1);
    set_op(2, -100, -100, 1'b0);
    set_op(3, 127, -128, 1'b1);
    req = 4'b1111;
    @(negedge clock);
    reset_n = 1'b1;
    for (int s = 0; s < 5; s++) begin
      g = s % 4;
      @(negedge clock);
      checks++; if (ack !== 4'(1 << g)) begin errors++; $display("FAIL rr_ack slot %0d got %b want %b", s, ack, 4'(1 << g)); end
      @(negedge clock);
      checks++; if (done !== 4'(1 << g)) begin errors++; $display("FAIL rr_done slot %0d got %b want %b", s, done, 4'(1 << g)); end
      checks++; if (res !== 9'(ea[g])) begin errors++; $display("FAIL rr_res slot %0d got %0d want %0d", s, res, ea[g]); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rr_ovf slot %0d got %b want 0", s, ovf); end
      @(negedge clock);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_idle slot %0d busy got %b want 0", s, busy); end
      if (s == 4) req = 4'b0000;
    end
    @(negedge clock);
    checks++; if (busy !== 1'b0 || ack !== 4'b0000) begin errors++; $display("FAIL rr_quiet busy %b ack %b want 0 0000", busy, ack); end
  endtask

  task automatic test_fairness();
    int g;
    @(negedge clock);
    reset_n = 1'b0;
    set_op(0, 1, 2, 1'b0);
    set_op(1, 9, 9, 1'b0);
    set_op(2, -3, 4, 1'b1);
    set_op(3, 9, 9, 1'b0);
    req = 4'b0101;
    @(negedge clock);
    reset_n = 1'b1;
    for (int s = 0; s < 4; s++) begin
      g = (s % 2 == 0) ? 0 : 2;
      @(negedge clock);
      checks++; if (ack !== 4'(1 << g)) begin errors++; $display("FAIL fair_ack slot %0d got %b want %b", s, ack, 4'(1 << g)); end
      @(negedge clock);
      checks++; if (res !== ((g == 0) ? 9'd3 : 9'(-7))) begin errors++; $display("FAIL fair_res slot %0d got %0d want %0d", s, res, (g == 0) ? 3 : -7); end
      @(negedge clock);
      if (s == 3) req = 4'b0000;
    end
    @(negedge clock);
  endtask

  task automatic test_mid_reset();
    set_op(0, 5, 6, 1'b0);
    req = 4'b0001;
    @(negedge clock);
    checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL midrst_exec_ack got %b want 0001", ack); end
    reset_n = 1'b0;
    #1;
    checks++; if (done !== 4'b0000) begin errors++; $display("FAIL midrst_done got %b want 0000", done); end
    checks++; if (res !== 9'd0) begin errors++; $display("FAIL midrst_res got %0d want 0", res); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL midrst_ovf got %b want 0", ovf); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
    set_op(3, 1, 1, 1'b0);
    set_op(0, 7, 1, 1'b1);
    req = 4'b1001;
    @(negedge clock);
    checks++; if (done !== 4'b0000) begin errors++; $display("FAIL midrst_held_done got %b want 0000", done); end
    reset_n = 1'b1;
    @(negedge clock);
    checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL midrst_first_grant got %b want 0001", ack); end
    req = 4'b0000;
    @(negedge clock);
    checks++; if (done !== 4'b0001) begin errors++; $display("FAIL midrst_after_done got %b want 0001", done); end
    checks++; if (res !== 9'd6) begin errors++; $display("FAIL midrst_after_res got %0d want 6", res); end
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_single();
    test_add_ovf();
    test_sub_ovf();
    test_round_robin();
    test_fairness();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
